// File: rtl/zap_fetch_queue_pkg.sv
// Shared entry layout for the fetch queue: bit offsets into the 99-bit entry
// and a packed struct view of the same layout.
package zap_fetch_queue_pkg;

  localparam int FQ_INSTR_LSB = 0;
  localparam int FQ_ABORT_BIT = 32;
  localparam int FQ_PC_LSB    = 33;
  localparam int FQ_PC8_LSB   = 65;
  localparam int FQ_TAKEN_LSB = 97;
  localparam int FQ_W         = 99;

  // Field order, MSB first, matches the offsets above.
  typedef struct packed {
    logic [1:0]  taken;
    logic [31:0] pc_plus_8;
    logic [31:0] pc;
    logic        iabort;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/zap_fetch_queue_if.sv
// Fetch-to-decode handshake bundle; master is the fetch/decode environment,
// slave is the queue itself.
interface zap_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_clear;
  logic          i_stall;
  logic [31:0]   i_instruction;
  logic          i_valid;
  logic          i_iabort;
  logic [31:0]   i_pc_ff;
  logic [31:0]   i_pc_plus_8_ff;
  logic [1:0]    i_taken;
  logic          o_stall_to_fetch;
  logic [31:0]   o_instruction;
  logic          o_valid;
  logic          o_iabort;
  logic [31:0]   o_pc_ff;
  logic [31:0]   o_pc_plus_8_ff;
  logic [1:0]    o_taken;
  logic [CW-1:0] o_count;

  modport master (
    output i_clear, i_stall, i_instruction, i_valid, i_iabort,
           i_pc_ff, i_pc_plus_8_ff, i_taken,
    input  o_stall_to_fetch, o_instruction, o_valid, o_iabort,
           o_pc_ff, o_pc_plus_8_ff, o_taken, o_count
  );

  modport slave (
    input  i_clear, i_stall, i_instruction, i_valid, i_iabort,
           i_pc_ff, i_pc_plus_8_ff, i_taken,
    output o_stall_to_fetch, o_instruction, o_valid, o_iabort,
           o_pc_ff, o_pc_plus_8_ff, o_taken, o_count
  );
endinterface

// File: rtl/zap_fetch_queue_mem.sv
// Register-array storage for the fetch queue: synchronous write, asynchronous
// read, every entry cleared by reset.
module zap_sync_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 99
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clk) begin
        if (i_reset)
          mem_reg[gi] <= '0;
        else if (wr_en && (wr_addr == gi[$clog2(DEPTH)-1:0]))
          mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/zap_fetch_queue.sv
// Prefetch queue between I-cache output and the Thumb decoder. Status flags
// come straight from the registered count so no input reaches them.
module zap_fetch_queue
  import zap_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  zap_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("zap_fetch_queue: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          full, not_empty, push, pop;
  fq_entry_t     wr_entry;
  logic [FQ_W-1:0] rd_data;

  assign full      = (count_reg == CW'(DEPTH));
  assign not_empty = (count_reg != '0);
  assign push      = bus.i_valid & ~full;
  assign pop       = not_empty & ~bus.i_stall;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (bus.i_clear) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  always_comb begin
    wr_entry.taken     = bus.i_taken;
    wr_entry.pc_plus_8 = bus.i_pc_plus_8_ff;
    wr_entry.pc        = bus.i_pc_ff;
    wr_entry.iabort    = bus.i_iabort;
    wr_entry.instr     = bus.i_instruction;
  end

  // A push in a flush cycle must not leave a stale word behind.
  zap_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (FQ_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .wr_en   (push & ~bus.i_clear),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  assign bus.o_instruction    = rd_data[FQ_INSTR_LSB +: 32];
  assign bus.o_iabort         = rd_data[FQ_ABORT_BIT];
  assign bus.o_pc_ff          = rd_data[FQ_PC_LSB +: 32];
  assign bus.o_pc_plus_8_ff   = rd_data[FQ_PC8_LSB +: 32];
  assign bus.o_taken          = rd_data[FQ_TAKEN_LSB +: 2];
  assign bus.o_valid          = not_empty;
  assign bus.o_stall_to_fetch = full;
  assign bus.o_count          = count_reg;

  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_reset)
    !(pop && !not_empty));

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Directed bench for zap_fetch_queue: a vector table for single-cycle
// behaviour plus a hand-written abort/reset sequence.
module tb_zap_fetch_queue;
  import zap_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic i_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  zap_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  zap_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    logic        clear, stall, valid, iabort;
    logic [1:0]  taken;
    logic [31:0] instr, pc;
    logic        ev, es;
    logic [2:0]  ec;
    logic        dchk;
    logic [31:0] ei, ep;
    logic        ea;
    logic [1:0]  et;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic clear, input logic stall, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc,
                         input logic ev, input logic es, input logic [2:0] ec,
                         input logic dchk, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.clear = clear; v.stall = stall; v.valid = valid; v.iabort = 1'b0;
    v.taken = 2'b00; v.instr = instr; v.pc = pc;
    v.ev = ev; v.es = es; v.ec = ec; v.dchk = dchk;
    v.ei = ei; v.ep = ep; v.ea = 1'b0; v.et = 2'b00;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clear, input logic stall, input logic valid,
                       input logic iabort, input logic [1:0] taken,
                       input logic [31:0] instr, input logic [31:0] pc);
    bus.i_clear        = clear;
    bus.i_stall        = stall;
    bus.i_valid        = valid;
    bus.i_iabort       = iabort;
    bus.i_taken        = taken;
    bus.i_instruction  = instr;
    bus.i_pc_ff        = pc;
    bus.i_pc_plus_8_ff = pc + 32'd8;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, ".stall"}, 64'(bus.o_stall_to_fetch), 64'd0);
    chk({tag, ".count"}, 64'(bus.o_count), 64'd0);
    chk({tag, ".instr"}, 64'(bus.o_instruction), 64'd0);
    chk({tag, ".pc"}, 64'(bus.o_pc_ff), 64'd0);
    chk({tag, ".pc8"}, 64'(bus.o_pc_plus_8_ff), 64'd0);
    chk({tag, ".iabort"}, 64'(bus.o_iabort), 64'd0);
    chk({tag, ".taken"}, 64'(bus.o_taken), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single push into an empty queue, then drain it.
    add_vec(0, 0, 1, 32'hE1A00000, 32'h100, 1, 0, 1, 1, 32'hE1A00000, 32'h100);
    add_vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Fill under stall; head stays on the first word, fifth push ignored.
    for (int k = 0; k < 4; k++)
      add_vec(0, 1, 1, 32'hA0000000 + k, 32'h200 + 4 * k, 1, k == 3, 3'(k + 1),
              1, 32'hA0000000, 32'h200);
    add_vec(0, 1, 1, 32'hBAD00000, 32'h210, 1, 1, 4, 1, 32'hA0000000, 32'h200);
    // Full with stall released: pop wins, push rejected, then drain in order.
    add_vec(0, 0, 1, 32'hBAD00001, 32'h214, 1, 0, 3, 1, 32'hA0000001, 32'h204);
    add_vec(0, 0, 0, 32'h0, 32'h0, 1, 0, 2, 1, 32'hA0000002, 32'h208);
    add_vec(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 1, 32'hA0000003, 32'h20C);
    add_vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Three entries then a flush with a simultaneous push.
    for (int k = 0; k < 3; k++)
      add_vec(0, 1, 1, 32'hC0000000 + k, 32'h300 + 4 * k, 1, 0, 3'(k + 1),
              1, 32'hC0000000, 32'h300);
    add_vec(1, 1, 1, 32'hDEAD0000, 32'h3F0, 0, 0, 0, 0, 32'h0, 32'h0);
    add_vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    add_vec(0, 0, 1, 32'hE0000000, 32'h400, 1, 0, 1, 1, 32'hE0000000, 32'h400);
    add_vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    // Streaming push+pop across several pointer wraps.
    for (int k = 0; k < 10; k++)
      add_vec(0, 0, 1, 32'h50000000 + k, 32'(4 * k), 1, 0, 1,
              1, 32'h50000000 + k, 32'(4 * k));
    add_vec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

    i_reset = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    step();
    i_reset = 1'b0;
    chk_all_zero("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clear, vecs[i].stall, vecs[i].valid, vecs[i].iabort,
            vecs[i].taken, vecs[i].instr, vecs[i].pc);
      step();
      $display("vec %0d clr=%0b stl=%0b vld=%0b pc=%h -> valid=%0b full=%0b count=%0d head_pc=%h",
               i, vecs[i].clear, vecs[i].stall, vecs[i].valid, vecs[i].pc,
               bus.o_valid, bus.o_stall_to_fetch, bus.o_count, bus.o_pc_ff);
      chk($sformatf("v%0d.valid", i), 64'(bus.o_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d.stall", i), 64'(bus.o_stall_to_fetch), 64'(vecs[i].es));
      chk($sformatf("v%0d.count", i), 64'(bus.o_count), 64'(vecs[i].ec));
      if (vecs[i].dchk) begin
        chk($sformatf("v%0d.instr", i), 64'(bus.o_instruction), 64'(vecs[i].ei));
        chk($sformatf("v%0d.pc", i), 64'(bus.o_pc_ff), 64'(vecs[i].ep));
        chk($sformatf("v%0d.pc8", i), 64'(bus.o_pc_plus_8_ff), 64'(vecs[i].ep + 32'd8));
        chk($sformatf("v%0d.iabort", i), 64'(bus.o_iabort), 64'(vecs[i].ea));
        chk($sformatf("v%0d.taken", i), 64'(bus.o_taken), 64'(vecs[i].et));
      end
    end

    // Aborted word with predictor state, then reset while entries are queued.
    drive(0, 0, 1, 1, 2'b11, 32'hF0000000, 32'h500);
    step();
    $display("abort push -> valid=%0b iabort=%0b taken=%0b count=%0d",
             bus.o_valid, bus.o_iabort, bus.o_taken, bus.o_count);
    chk("abort.count", 64'(bus.o_count), 64'd1);
    chk("abort.iabort", 64'(bus.o_iabort), 64'd1);
    chk("abort.taken", 64'(bus.o_taken), 64'd3);
    chk("abort.instr", 64'(bus.o_instruction), 64'hF0000000);
    chk("abort.pc", 64'(bus.o_pc_ff), 64'h500);
    chk("abort.pc8", 64'(bus.o_pc_plus_8_ff), 64'h508);
    drive(0, 1, 1, 0, 2'b01, 32'hF0000001, 32'h504);
    step();
    $display("stalled push -> count=%0d", bus.o_count);
    chk("abort2.count", 64'(bus.o_count), 64'd2);
    chk("abort2.head_iabort", 64'(bus.o_iabort), 64'd1);
    i_reset = 1'b1;
    drive(0, 0, 1, 1, 2'b10, 32'hF0000002, 32'h508);
    step();
    i_reset = 1'b0;
    $display("mid reset -> valid=%0b count=%0d instr=%h", bus.o_valid, bus.o_count, bus.o_instruction);
    chk_all_zero("midreset");
    drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
    step();
    $display("post reset idle -> valid=%0b count=%0d", bus.o_valid, bus.o_count);
    chk_all_zero("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
